pet2001_arty: RTL and testbench
===============================

Name: pet2001_arty

Overview:
- Board-level top of the PET 2001 emulation on the Arty board, driven by the 100 MHz board clock.
- Owns the reset synchronizer, switch synchronizers, CPU clock-enable generator, video timing generator, 2-bit composite video encoder and LED heartbeat.
- Instantiates the PET machine core (CPU, RAM/ROM, PIAs/VIA, UART key/terminal bridge), which fetches display pixels through a character-address interface.

Parameters:
- CLK_HZ, 100000000, board clock frequency.
- CPU_DIV, 100, clocks per CPU enable in normal mode (1 MHz).
- TURBO_DIV, 10, clocks per CPU enable in turbo mode (10 MHz).
- PIX_DIV, 10, clocks per pixel slot (10 MHz pixel rate).
- LED_HALF, 50000000, clocks per LED toggle (1 Hz blink).

Ports:
- CLK  in  1  100 MHz board clock; all logic in this domain.
- BTN  in  1  reset; asynchronous, active-high.
- SW  in  3  SW[0] diag, SW[1] turbo, SW[2] suspend; asynchronous inputs.
- UART_TXD_IN  in  1  serial from host; idles 1; passed to the core.
- UART_RXD_OUT  out  1  serial to host; driven by the core; idles 1.
- COMPVID  out  2  composite level: 00 sync, 01 black, 11 white; 10 is never driven.
- LED  out  1  heartbeat.

Behaviour:
- Reset synchronizer:
  - BTN asserts the internal reset asynchronously.
  - Deassertion is released through 2 flops, so reset ends 2 CLK edges after BTN falls.
  - All wrapper registers are reset by it, and it is passed to the core.
- SW synchronization and modes:
  - Each SW bit passes through 2 flops before use.
  - SW[0] is passed to the core as the diag key.
- CPU enable ce_cpu:
  - Single-CLK pulse every CPU_DIV clocks; every TURBO_DIV clocks when synced SW[1]=1.
  - Forced 0 when synced SW[2]=1; the divider counter freezes while suspended.
  - A turbo change takes effect after the next pulse, or immediately if the counter already exceeds the new divisor.
  - Held 0 during reset.
  - First pulse comes CPU_DIV clocks after reset release.
- Pixel slots: pix_ce pulses once every PIX_DIV clocks.
- Horizontal counter hcnt:
  - Range 0..639 slots, which is a 64 µs line; advances on pix_ce.
  - hsync occupies slots 0..46.
  - Active region is slots 200..519, giving 320 pixels.
- Vertical counter vcnt:
  - Range 0..261 lines; increments when hcnt wraps 639→0.
  - vsync occupies lines 0..2.
  - Active region is lines 40..239, giving 200 lines.
- Core interface:
  - Inputs to the core: vid_addr[9:0] = char_row*40 + char_col, where char_row = (vcnt-40)>>3 and char_col = (hcnt-200)>>3.
  - Inputs to the core: char_line[2:0] = (vcnt-40)&7 and pix_col[2:0] = (hcnt-200)&7.
  - Inputs to the core: video_on = 1 during active lines, used by the core for the retrace interrupt.
  - The core returns pix_bit, valid before the end of the slot.
  - The wrapper samples pix_bit on the last CLK of the slot and displays it in the following slot, i.e. 1 slot of pixel latency.
  - The active window is shifted by that 1 slot.
- COMPVID mapping:
  - 00 during hsync, and during vsync lines for the whole line.
  - 11 when the delayed pixel is active and pix_bit=1.
  - 01 otherwise.
  - Registered output; 01 during reset.
- Counter reset values: hcnt=0, vcnt=0, the divider counters=0.
- LED:
  - Toggles every LED_HALF clocks.
  - Forced 0 during reset.
  - Stays frozen while suspended.
- UART_RXD_OUT is 1 during reset.

Decomposition:
- Shared package pet_pkg holds the timing constants H_TOTAL=640, H_SYNC=47, H_ACT0=200, H_ACT=320, V_TOTAL=262, V_SYNC=3, V_ACT0=40, V_ACT=200, the COMPVID level codes, and the SW bit index constants.
- One natural sub-module: pet2001_core (machine core).
- The video timing generator stays inline in this block.

Test Plan:
- Reset: BTN=1 for 20 clocks, then 0 → COMPVID=01, LED=0, UART_RXD_OUT=1 through reset; reset internally releases exactly 2 edges after BTN falls.
- Normal CPU enable: SW=000 → ce_cpu pulses every 100 clocks, first pulse 100 clocks after release; pulse width 1 clock.
- Turbo and suspend: SW[1]=1 → period 10 clocks after sync; then SW[2]=1 → no pulses and LED frozen; SW[2]=0 → pulses resume from the frozen count.
- Line timing: COMPVID=00 for 470 clocks at each line start; line length 6400 clocks; 00 held for all of lines 0..2; frame period 262 lines = 1676800 clocks.
- Pixel path: core stub returns pix_bit=1 only for vid_addr=0 and pix_col=0 → one 10-clock 11 pulse on line 40 at slot 201; all else 01 in the active area.
- LED: after release, LED rises at 50,000,000 clocks and falls at 100,000,000.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared PET 2001 video timing constants, composite level codes and switch indices.
package pet_pkg;

    localparam int H_TOTAL = 640;
    localparam int H_SYNC  = 47;
    localparam int H_ACT0  = 200;
    localparam int H_ACT   = 320;
    localparam int V_TOTAL = 262;
    localparam int V_SYNC  = 3;
    localparam int V_ACT0  = 40;
    localparam int V_ACT   = 200;

    localparam int SW_DIAG    = 0;
    localparam int SW_TURBO   = 1;
    localparam int SW_SUSPEND = 2;

    typedef enum logic [1:0] {
        CV_SYNC  = 2'b00,
        CV_BLACK = 2'b01,
        CV_WHITE = 2'b11
    } compvid_t;

    function automatic logic in_span(input int x, input int lo, input int len);
        return (x >= lo) && (x < lo + len);
    endfunction

endpackage

// File: rtl/pet2001_core.sv
// Stand-in PET machine core: echoes the host serial line at the CPU rate and
// marks the first dot of character cell 0; diag whitens the whole active area.
module pet2001_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_cpu,
    input  logic       diag,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic [9:0] vid_addr,
    input  logic [2:0] char_line,
    input  logic [2:0] pix_col,
    input  logic       video_on,
    output logic       pix_bit
);

    logic marker;

    assign marker  = (vid_addr == 10'd0) && (char_line == 3'd0) && (pix_col == 3'd0);
    assign pix_bit = video_on && (diag || marker);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_tx <= 1'b1;
        end else if (ce_cpu) begin
            uart_tx <= uart_rx;
        end
    end

endmodule

// File: rtl/pet2001_arty.sv
// Arty board top for the PET 2001: reset/switch sync, CPU clock enable,
// video timing, composite encoder and heartbeat around the machine core.
module pet2001_arty
    import pet_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int CPU_DIV   = 100,
    parameter int TURBO_DIV = 10,
    parameter int PIX_DIV   = 10,
    parameter int LED_HALF  = 50000000
) (
    input  logic       CLK,
    input  logic       BTN,
    input  logic [2:0] SW,
    input  logic       UART_TXD_IN,
    output logic       UART_RXD_OUT,
    output logic [1:0] COMPVID,
    output logic       LED
);

    localparam int CPU_MAX = (CPU_DIV > TURBO_DIV) ? CPU_DIV : TURBO_DIV;
    localparam int CW = $clog2(CPU_MAX + 1);
    localparam int PW = $clog2(PIX_DIV + 1);
    localparam int LW = $clog2(CLK_HZ + 1);

    logic          rst_meta, rst;
    logic [2:0]    sw_meta, sw_sync;
    logic          turbo, suspend;
    logic [CW-1:0] cpu_cnt, cpu_last;
    logic          ce_cpu;
    logic [PW-1:0] pix_cnt;
    logic          pix_ce;
    logic [9:0]    hcnt, h_next;
    logic [8:0]    vcnt, v_next;
    logic [8:0]    h_rel;
    logic [7:0]    v_rel;
    logic          h_act, v_act, sync_next;
    logic [9:0]    vid_addr;
    logic          pix_bit;
    compvid_t      compvid;
    logic [LW-1:0] led_cnt;
    logic          led;

    always_ff @(posedge CLK or posedge BTN) begin
        if (BTN) begin
            rst_meta <= 1'b1;
            rst      <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst      <= rst_meta;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    assign turbo    = sw_sync[SW_TURBO];
    assign suspend  = sw_sync[SW_SUSPEND];
    assign cpu_last = turbo ? CW'(TURBO_DIV - 1) : CW'(CPU_DIV - 1);

    // Comparing with >= lets a switch to turbo fire at once when the count is already past the short period.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cpu_cnt <= '0;
            ce_cpu  <= 1'b0;
        end else if (suspend) begin
            ce_cpu <= 1'b0;
        end else if (cpu_cnt >= cpu_last) begin
            cpu_cnt <= '0;
            ce_cpu  <= 1'b1;
        end else begin
            cpu_cnt <= cpu_cnt + CW'(1);
            ce_cpu  <= 1'b0;
        end
    end

    assign pix_ce = (pix_cnt == PW'(PIX_DIV - 1));

    assign h_next = (hcnt == 10'(H_TOTAL - 1)) ? 10'd0 : hcnt + 10'd1;
    assign v_next = (hcnt != 10'(H_TOTAL - 1)) ? vcnt :
                    (vcnt == 9'(V_TOTAL - 1))  ? 9'd0 : vcnt + 9'd1;

    assign h_act     = in_span(int'(hcnt), H_ACT0, H_ACT);
    assign v_act     = in_span(int'(vcnt), V_ACT0, V_ACT);
    assign sync_next = (int'(h_next) < H_SYNC) || (int'(v_next) < V_SYNC);

    assign h_rel    = 9'(hcnt - 10'(H_ACT0));
    assign v_rel    = 8'(vcnt - 9'(V_ACT0));
    assign vid_addr = ({5'd0, v_rel[7:3]} * 10'd40) + {4'd0, h_rel[8:3]};

    // COMPVID is loaded at the slot boundary with the level of the slot being entered,
    // so the pixel sampled at the end of one slot is shown throughout the next.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
            hcnt    <= '0;
            vcnt    <= '0;
            compvid <= CV_BLACK;
        end else begin
            pix_cnt <= pix_ce ? '0 : pix_cnt + PW'(1);
            if (pix_ce) begin
                hcnt <= h_next;
                vcnt <= v_next;
                if (sync_next) begin
                    compvid <= CV_SYNC;
                end else if (h_act && v_act && pix_bit) begin
                    compvid <= CV_WHITE;
                end else begin
                    compvid <= CV_BLACK;
                end
            end
        end
    end

    assign COMPVID = compvid;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            led_cnt <= '0;
            led     <= 1'b0;
        end else if (!suspend) begin
            if (led_cnt == LW'(LED_HALF - 1)) begin
                led_cnt <= '0;
                led     <= ~led;
            end else begin
                led_cnt <= led_cnt + LW'(1);
            end
        end
    end

    assign LED = led;

    pet2001_core u_core (
        .clk       (CLK),
        .rst       (rst),
        .ce_cpu    (ce_cpu),
        .diag      (sw_sync[SW_DIAG]),
        .uart_rx   (UART_TXD_IN),
        .uart_tx   (UART_RXD_OUT),
        .vid_addr  (vid_addr),
        .char_line (v_rel[2:0]),
        .pix_col   (h_rel[2:0]),
        .video_on  (v_act),
        .pix_bit   (pix_bit)
    );

endmodule

// File: tb/tb_pet2001_arty.sv
// Bench for pet2001_arty: reset, CPU enable scheduling, LED heartbeat and
// composite video levels, with shortened pixel and LED periods.
module tb_pet2001_arty;

    localparam int PIX_DIV  = 2;
    localparam int LED_HALF = 500;

    typedef struct {
        int         line;
        int         slot;
        logic [1:0] level;
    } vid_vec_t;

    logic       clk = 1'b0;
    logic       btn;
    logic [2:0] sw;
    logic       uart_txd;
    logic       uart_rxd;
    logic [1:0] compvid;
    logic       led;

    int       vectors = 0;
    int       miscompares = 0;
    int       cyc = 0;
    int       c_rel = 0;
    logic     mon_en = 1'b0;
    int       exp_q[$];
    vid_vec_t vecs[16];

    pet2001_arty #(
        .CPU_DIV   (100),
        .TURBO_DIV (10),
        .PIX_DIV   (PIX_DIV),
        .LED_HALF  (LED_HALF)
    ) dut (
        .CLK          (clk),
        .BTN          (btn),
        .SW           (sw),
        .UART_TXD_IN  (uart_txd),
        .UART_RXD_OUT (uart_rxd),
        .COMPVID      (compvid),
        .LED          (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int tnow();
        return cyc - c_rel;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0d)", name, actual, expected, tnow());
        end
    endtask

    task automatic wait_until(input int target);
        if (tnow() > target) check("schedule late", tnow(), target);
        while (tnow() < target) @(negedge clk);
    endtask

    task automatic wait_pulse(output int p);
        p = -1;
        for (int i = 0; i < 50 && p < 0; i++) begin
            @(negedge clk);
            if (dut.ce_cpu === 1'b1) p = tnow();
        end
        if (p < 0) begin
            check("ce_cpu pulse found", 0, 1);
            p = tnow();
        end
    endtask

    // Scoreboard side: every CPU enable pulse seen while armed must match the oldest queued time.
    always @(negedge clk) begin
        if (mon_en && dut.ce_cpu === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ce_cpu unexpected pulse", tnow(), -1);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("ce_cpu pulse time", tnow(), e);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p, u;
        logic led0;

        vecs[0]  = '{2,   0,   2'b00};
        vecs[1]  = '{2,   300, 2'b00};
        vecs[2]  = '{2,   639, 2'b00};
        vecs[3]  = '{3,   0,   2'b00};
        vecs[4]  = '{3,   46,  2'b00};
        vecs[5]  = '{3,   47,  2'b01};
        vecs[6]  = '{3,   250, 2'b01};
        vecs[7]  = '{39,  201, 2'b01};
        vecs[8]  = '{39,  639, 2'b01};
        vecs[9]  = '{40,  46,  2'b00};
        vecs[10] = '{40,  200, 2'b01};
        vecs[11] = '{40,  201, 2'b11};
        vecs[12] = '{40,  202, 2'b01};
        vecs[13] = '{40,  209, 2'b01};
        vecs[14] = '{40,  520, 2'b01};
        vecs[15] = '{41,  201, 2'b01};

        btn = 1'b1;
        sw = 3'b000;
        uart_txd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5 || i == 19) begin
                check("reset COMPVID", int'(compvid), 1);
                check("reset LED", int'(led), 0);
                check("reset UART_RXD_OUT", int'(uart_rxd), 1);
                check("reset ce_cpu", int'(dut.ce_cpu), 0);
            end
        end
        btn = 1'b0;
        @(negedge clk);
        check("reset held one edge after BTN", int'(dut.rst), 1);
        @(negedge clk);
        check("reset released two edges after BTN", int'(dut.rst), 0);
        c_rel = cyc;
        uart_txd = 1'b1;

        $display("[TB] normal CPU enable");
        for (int k = 1; k <= 4; k++) exp_q.push_back(100 * k);
        mon_en = 1'b1;
        wait_until(450);
        check("normal pulses outstanding", exp_q.size(), 0);
        mon_en = 1'b0;

        wait_until(LED_HALF - 1);
        check("LED before first rise", int'(led), 0);
        wait_until(LED_HALF);
        check("LED first rise", int'(led), 1);

        $display("[TB] turbo CPU enable");
        sw = 3'b010;
        wait_until(620);
        wait_pulse(p);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) exp_q.push_back(p + 10 * k);
        mon_en = 1'b1;
        wait_until(p + 45);
        check("turbo pulses outstanding", exp_q.size(), 0);
        mon_en = 1'b0;

        wait_until(2 * LED_HALF - 1);
        check("LED before fall", int'(led), 1);
        wait_until(2 * LED_HALF);
        check("LED fall", int'(led), 0);

        $display("[TB] suspend and resume");
        wait_pulse(p);
        wait_until(p + 3);
        sw = 3'b110;
        wait_until(p + 8);
        mon_en = 1'b1;
        led0 = led;
        for (int k = 1; k <= 6; k++) begin
            wait_until(p + 8 + 100 * k);
            check("LED frozen while suspended", int'(led), int'(led0));
        end
        u = tnow();
        sw = 3'b010;
        for (int k = 0; k < 3; k++) exp_q.push_back(u + 7 + 10 * k);
        wait_until(u + 30);
        check("resume pulses outstanding", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("[TB] composite video levels");
        for (int i = 0; i < 16; i++) begin
            wait_until(PIX_DIV * (vecs[i].line * 640 + vecs[i].slot) + PIX_DIV - 1);
            check($sformatf("COMPVID line %0d slot %0d", vecs[i].line, vecs[i].slot),
                  int'(compvid), int'(vecs[i].level));
        end

        @(negedge clk);
        #2 btn = 1'b1;
        #1 check("asynchronous reset assert", int'(dut.rst), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
